button_debounce_fsm: RTL and testbench
======================================

BUTTON_DEBOUNCE_FSM -- requirements
Module: button_debounce_fsm

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 500000, meaning consecutive synchronized cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2**CNT_WIDTH-1.
REQ-002 SHALL have parameter CNT_WIDTH, default 20, meaning stability counter width.
REQ-003 SHALL have port clock  input  1  the single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port button_in  input  1  raw asynchronous pushbutton level.
REQ-006 SHALL have port clear_count  input  1  synchronous clear of press_count.
REQ-007 SHALL have port db_out  output  1  debounced button level, registered; drives the RAM's button input word.
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe on accepted 0->1 change.
REQ-009 SHALL have port release_pulse  output  1  one-cycle strobe on accepted 1->0 change.
REQ-010 SHALL have port press_count  output  32  accepted presses, suitable as a RAM data word.
REQ-011 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-012 SHALL pass button_in through a two-flop synchronizer; the FSM sees only the second flop (s).
REQ-013 SHALL implement states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-014 IDLE_LOW: s=1 -> WAIT_HIGH with cnt=0; else stay.
REQ-015 WAIT_HIGH: s=0 -> IDLE_LOW, cnt=0 (bounce rejected, no pulse); s=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH; s=1 otherwise -> cnt+1.
REQ-016 IDLE_HIGH/WAIT_LOW SHALL mirror REQ-014/015 with polarity inverted, committing to IDLE_LOW.
REQ-017 db_out SHALL be 1 exactly in IDLE_HIGH and WAIT_LOW, registered (no combinational path from button_in).
REQ-018 Latency: button_in stable from before edge 1 -> db_out changes after rising edge STABLE_CYCLES+3.
REQ-019 press_pulse SHALL be 1 for exactly the cycle after commit to IDLE_HIGH; release_pulse likewise for IDLE_LOW; never both high.
REQ-020 press_count SHALL increment by 1 in the same edge that commits to IDLE_HIGH, modulo 2**32 (0xFFFFFFFF -> 0x00000000).
REQ-021 clear_count SHALL set press_count to 0 on the next edge; clear and commit in same cycle -> count 0, press_pulse still asserted.
REQ-022 cnt SHALL never exceed STABLE_CYCLES-1; no overflow path.

Reset
REQ-023 reset SHALL override all other inputs on the edge it is sampled.
REQ-024 After reset: state IDLE_LOW, cnt 0, synchronizer flops 0, db_out 0, press_pulse 0, release_pulse 0, press_count 0.
REQ-025 reset asserted mid-WAIT or while held high SHALL discard progress; a still-held button re-qualifies for the full REQ-018 latency, counting one press.

Structure
REQ-026 State encoding constants and parameter defaults SHALL live in a shared package.
REQ-027 The synchronizer SHALL be a sub-module named sync_2ff (1-bit, reset to 0).
REQ-028 Target 120-400 lines RTL; no latches, no multi-driven signals.

Verification (STABLE_CYCLES=4 unless noted)
REQ-029 reset, button_in 0->1 held -> db_out=1 after edge 7, press_pulse single cycle, press_count=1.
REQ-030 Glitch: button_in high 3 cycles then low -> db_out stays 0, no pulses, press_count=0.
REQ-031 Release: from IDLE_HIGH button_in 0 held -> db_out=0 after edge 7, release_pulse one cycle, press_count unchanged.
REQ-032 Wrap: force press_count=0xFFFFFFFF, one clean press -> 0x00000000; clear_count with commit same cycle -> 0, press_pulse=1.
REQ-033 reset pulse during WAIT_HIGH (cnt=2) with button held -> outputs 0, db_out=1 again 7 edges after reset release, press_count=1.

Source files
------------

// File: rtl/button_debounce_fsm_pkg.sv
// +--------------------------------------------------------------------+
// | button_debounce_fsm_pkg : shared state encoding and defaults        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package button_debounce_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned c_STABLE_CYCLES_DEFAULT = 500000;
  localparam int unsigned c_CNT_WIDTH_DEFAULT     = 20;

  // Levels at which the debounced output reads as pressed.
  function automatic logic f_level_high(input state_t i_state);
    return (i_state == IDLE_HIGH) || (i_state == WAIT_LOW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +--------------------------------------------------------------------+
// | sync_2ff : 1-bit two-flop synchronizer, resets to 0                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_debounce_fsm.sv
// +--------------------------------------------------------------------+
// | button_debounce_fsm : synchronized pushbutton debouncer with        |
// | press/release strobes and a 32-bit press counter.  Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module button_debounce_fsm
  import button_debounce_fsm_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = c_STABLE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH     = c_CNT_WIDTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        button_in,
  input  logic        clear_count,
  output logic        db_out,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic [31:0] press_count
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

  logic                 w_sync;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_commit_high;
  logic                 w_commit_low;
  logic                 r_db;
  logic                 r_press;
  logic                 r_release;
  logic [31:0]          r_press_count;

  sync_2ff u_sync (
    .clk (clock),
    .rst (reset),
    .i_d (button_in),
    .o_q (w_sync)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter only runs while a candidate level is being qualified and
  // stops at c_CNT_LAST, where the commit takes over.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_commit_high = 1'b0;
    w_commit_low  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (w_sync) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = IDLE_HIGH;
          w_cnt_nxt     = '0;
          w_commit_high = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_sync) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt  = IDLE_LOW;
          w_cnt_nxt    = '0;
          w_commit_low = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Clear wins over a simultaneous press commit; the strobe still fires.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_db          <= 1'b0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_db      <= f_level_high(w_state_nxt);
      r_press   <= w_commit_high;
      r_release <= w_commit_low;
      if (clear_count) begin
        r_press_count <= '0;
      end else if (w_commit_high) begin
        r_press_count <= r_press_count + 32'd1;
      end
    end
  end

  assign db_out        = r_db;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign press_count   = r_press_count;

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_fsm.sv
// +--------------------------------------------------------------------+
// | tb_button_debounce_fsm : vector table, corner sequences and random  |
// | stimulus against a run-length reference model.  Rev 1.0             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_button_debounce_fsm;

  localparam int unsigned S = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        button_in = 1'b0;
  logic        clear_count = 1'b0;
  logic        db_out;
  logic        press_pulse;
  logic        release_pulse;
  logic [31:0] press_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  button_debounce_fsm #(
    .STABLE_CYCLES (S),
    .CNT_WIDTH     (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button_in     (button_in),
    .clear_count   (clear_count),
    .db_out        (db_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  // Reference: a level is accepted once the synchronized input has disagreed
  // with the current debounced level for S+1 consecutive samples.
  logic        m_sa, m_sb, m_db, m_pp, m_rp;
  int          m_run;
  logic [31:0] m_cnt;

  task automatic model_edge(input logic rst, input logic b, input logic clr);
    logic s;
    if (rst) begin
      m_sa = 0; m_sb = 0; m_db = 0; m_pp = 0; m_rp = 0; m_run = 0; m_cnt = 0;
    end else begin
      s    = m_sb;
      m_sb = m_sa;
      m_sa = b;
      m_pp = 0;
      m_rp = 0;
      if (s != m_db) begin
        m_run++;
        if (m_run == int'(S) + 1) begin
          m_db  = s;
          m_run = 0;
          if (s) begin m_pp = 1; m_cnt = m_cnt + 32'd1; end
          else m_rp = 1;
        end
      end else begin
        m_run = 0;
      end
      if (clr) m_cnt = 0;
    end
  endtask

  task automatic step(input logic rst, input logic b, input logic clr);
    @(negedge clock);
    reset = rst; button_in = b; clear_count = clr;
    @(posedge clock);
    model_edge(rst, b, clr);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic db, input logic pp,
                            input logic rp, input logic [31:0] cnt);
    check({tag, ".db_out"},        {31'd0, db_out},        {31'd0, db});
    check({tag, ".press_pulse"},   {31'd0, press_pulse},   {31'd0, pp});
    check({tag, ".release_pulse"}, {31'd0, release_pulse}, {31'd0, rp});
    check({tag, ".press_count"},   press_count,            cnt);
  endtask

  typedef struct {
    logic        rst, b, clr;
    logic        db, pp, rp;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic rst, input logic b, input logic clr,
                     input logic db, input logic pp, input logic rp, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.b = b; v.clr = clr; v.db = db; v.pp = pp; v.rp = rp; v.cnt = cnt;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    // press: accepted on the 7th edge of a held input
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 0, 1);
    add(2, 0, 1, 0, 1, 0, 0, 1);
    // release
    add(6, 0, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    // glitches of 3 and 4 cycles (one short of acceptance) are rejected
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 0, 0);
    add(6, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0, 0);
    add(6, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].b, tbl[i].clr);
      check_outs($sformatf("vec%0d", i), tbl[i].db, tbl[i].pp, tbl[i].rp, tbl[i].cnt);
    end

    // clear_count on the commit edge: count 0, strobe still fires
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    step(0, 1, 1);
    check_outs("clr_commit", 1, 1, 0, 0);
    step(0, 1, 0);
    check_outs("clr_commit_after", 1, 0, 0, 0);

    // counter wrap
    step(1, 0, 0);
    step(0, 0, 0);
    @(negedge clock);
    force dut.r_press_count = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.r_press_count;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", press_count, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    check_outs("wrap_pre", 0, 0, 0, 32'hFFFF_FFFF);
    step(0, 1, 0);
    check_outs("wrap", 1, 1, 0, 0);

    // reset in mid-qualification discards progress
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check_outs("midwait", 0, 0, 0, 0);
    step(1, 1, 0);
    check_outs("midwait_rst", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    check_outs("requal_pre", 0, 0, 0, 0);
    step(0, 1, 0);
    check_outs("requal", 1, 1, 0, 1);

    // random bursts against the reference model
    step(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 299) == 0), b, ($urandom_range(0, 39) == 0));
        check_outs("rand", m_db, m_pp, m_rp, m_cnt);
        check("rand.both_pulses", {31'd0, press_pulse & release_pulse}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
